// File: rtl/year_counter_pkg.sv
// Shared calendar definitions: year field width, default wrap value and the
// leap-year rule used by the year and day stages.
package year_counter_pkg;

  localparam int unsigned YEAR_W = 7;

  // Default last year value before the counter wraps back to 0.
  localparam logic [YEAR_W-1:0] YEAR_MAX_DEF = 7'd99;

  // Leap-year rule for a 100-year century window.
  // Year 0 of a century is a leap year only when the century is divisible by 4.
  // Every other year is a leap year when it is divisible by 4.
  // Divisibility by 4 needs only the two low bits of each operand.
  function automatic logic is_leap(input logic [YEAR_W-1:0] cen,
                                   input logic [YEAR_W-1:0] year);
    logic leap;
    if (year != '0) leap = (year[1:0] == 2'b00);
    else            leap = (cen[1:0]  == 2'b00);
    return leap;
  endfunction

endpackage

// File: rtl/year_counter_btn_edge.sv
// Button rising-edge detector. It registers the button level once per tick.
// The month, day, year and century buttons all share this block.
// The register clears to 0 on reset, so a button that is already held when
// reset is released counts as a press on the first tick.
module btn_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  logic btn_q;

  // Sample the button level every tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) btn_q <= 1'b0;
    else       btn_q <= btn_i;
  end

  assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/year_counter.sv
// Year-of-century counter (0..YEAR_MAX). It advances on the month-stage
// end_year carry or on a button press. It produces a registered end_century
// carry for the century stage and a combinational leap-year flag.
module year_counter
  import year_counter_pkg::*;
#(
  parameter logic [YEAR_W-1:0] YEAR_MAX   = YEAR_MAX_DEF,
  parameter logic [YEAR_W-1:0] RESET_YEAR = '0
) (
  input  logic              sig_1Hz,
  input  logic              reset,
  input  logic              yr_b,
  input  logic              end_year,
  input  logic              set_en,
  input  logic [YEAR_W-1:0] set_val,
  input  logic [YEAR_W-1:0] cen_i,
  output logic [YEAR_W-1:0] year_o,
  output logic              end_century,
  output logic              leap_o
);

  logic [YEAR_W-1:0] year_q, year_d;
  logic              ecen_q, ecen_d;
  logic              btn_rise;
  logic              inc;
  logic              at_max;

  btn_edge u_btn (
    .clk_i  (sig_1Hz),
    .rst_i  (reset),
    .btn_i  (yr_b),
    .rise_o (btn_rise)
  );

  // When end_year and a button press arrive together, they count as one increment.
  assign inc    = end_year | btn_rise;
  assign at_max = (year_q == YEAR_MAX);

  // Next-state logic. A load has the highest priority. An out-of-range load
  // value is ignored. Only an end_year wrap produces a carry; a wrap caused
  // by the button alone does not.
  always_comb begin
    year_d = year_q;
    ecen_d = 1'b0;
    if (set_en) begin
      if (set_val <= YEAR_MAX) year_d = set_val;
    end else if (inc) begin
      year_d = at_max ? '0 : year_q + 7'd1;
      ecen_d = end_year & at_max;
    end
  end

  // Year and carry registers. An asynchronous reset clears the carry pulse at once.
  always_ff @(posedge sig_1Hz or posedge reset) begin
    if (reset) begin
      year_q <= RESET_YEAR;
      ecen_q <= 1'b0;
    end else begin
      year_q <= year_d;
      ecen_q <= ecen_d;
    end
  end

  assign year_o      = year_q;
  assign end_century = ecen_q;
  assign leap_o      = is_leap(cen_i, year_q);

endmodule

// File: tb/tb_year_counter.sv
// Directed bench for year_counter. Expected values are hand-computed.
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
module tb_year_counter;

  logic       sig_1Hz = 1'b0;
  logic       reset   = 1'b1;
  logic       yr_b    = 1'b0;
  logic       end_year = 1'b0;
  logic       set_en  = 1'b0;
  logic [6:0] set_val = '0;
  logic [6:0] cen_i   = 7'd19;
  logic [6:0] year_o;
  logic       end_century;
  logic       leap_o;

  int n_tests = 0;
  int n_fail  = 0;

  year_counter dut (
    .sig_1Hz     (sig_1Hz),
    .reset       (reset),
    .yr_b        (yr_b),
    .end_year    (end_year),
    .set_en      (set_en),
    .set_val     (set_val),
    .cen_i       (cen_i),
    .year_o      (year_o),
    .end_century (end_century),
    .leap_o      (leap_o)
  );

  always #5 sig_1Hz = ~sig_1Hz;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sig_1Hz);
    #1;
  endtask

  task automatic load(input logic [6:0] v);
    set_en  = 1'b1;
    set_val = v;
    tick();
    set_en  = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_year", year_o, 0);
    chk("rst_ec", end_century, 0);
    #5 reset = 1'b0;        // released between edges
    tick();
    chk("idle_year", year_o, 0);

    // Five end_year carries: 0 -> 5, no carry out.
    end_year = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("ey_year%0d", i), year_o, i);
      chk($sformatf("ey_ec%0d", i), end_century, 0);
    end
    end_year = 1'b0;

    // Wrap by end_year at 99: carry for exactly one cycle.
    load(7'd99);
    chk("load99", year_o, 99);
    end_year = 1'b1;
    tick();
    end_year = 1'b0;
    chk("wrap_year", year_o, 0);
    chk("wrap_ec", end_century, 1);
    tick();
    chk("wrap_ec_off", end_century, 0);
    chk("wrap_year_hold", year_o, 0);

    // Wrap by the button alone: no carry; holding the button gives a single increment.
    load(7'd99);
    yr_b = 1'b1;
    tick();
    chk("btnwrap_year", year_o, 0);
    chk("btnwrap_ec", end_century, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("btnhold_year", year_o, 0);
    chk("btnhold_ec", end_century, 0);
    yr_b = 1'b0;
    tick();

    // end_year and a button rise on the same tick count as one increment.
    load(7'd10);
    yr_b = 1'b1; end_year = 1'b1;
    tick();
    yr_b = 1'b0; end_year = 1'b0;
    chk("both_year", year_o, 11);

    // Load path: an out-of-range value is ignored; a load takes priority over end_year.
    load(7'd120);
    chk("load_oor", year_o, 11);
    end_year = 1'b1;
    load(7'd42);
    end_year = 1'b0;
    chk("load_pri", year_o, 42);

    // A load at 99 together with end_year produces no carry.
    load(7'd99);
    end_year = 1'b1; set_en = 1'b1; set_val = 7'd99;
    tick();
    end_year = 1'b0; set_en = 1'b0;
    chk("load_ey_year", year_o, 99);
    chk("load_ey_ec", end_century, 0);

    // Leap-year flag.
    load(7'd4);  cen_i = 7'd19; #1;
    chk("leap_4_19", leap_o, 1);
    load(7'd0);  cen_i = 7'd19; #1;
    chk("leap_0_19", leap_o, 0);
    cen_i = 7'd20; #1;
    chk("leap_0_20", leap_o, 1);
    load(7'd1);  #1;
    chk("leap_1_20", leap_o, 0);
    cen_i = 7'd100; load(7'd0); #1;
    chk("leap_0_100", leap_o, 1);

    // Asynchronous reset while end_century is high.
    load(7'd99);
    end_year = 1'b1;
    tick();
    end_year = 1'b0;
    chk("pre_rst_ec", end_century, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ec", end_century, 0);
    chk("async_rst_year", year_o, 0);
    #1 reset = 1'b0;

    // Asynchronous reset from a nonzero year, without waiting for a clock edge.
    load(7'd42);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_y42", year_o, 0);

    // A button already held when reset is released counts as a press.
    yr_b = 1'b1;
    #1 reset = 1'b0;
    tick();
    chk("held_btn_year", year_o, 1);
    tick();
    chk("held_btn_hold", year_o, 1);
    yr_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
